rca_arbiter: RTL and testbench
==============================

# rca_arbiter

Shares one 32-bit ripple-carry add/subtract datapath among four requesters. Each requester presents operands on a valid/ready handshake. A round-robin arbiter grants one request per cycle, and the result is returned through a single-entry registered response buffer tagged with the requester ID. A lock/chain mechanism lets one requester issue an uninterrupted multi-word operation with carry propagated between words.

## Interface
Parameters:
- NREQ, 4, number of requesters; fixed at 4 because the ID is 2 bits.
- WIDTH, 32, operand width; fixed at 32 to match the adder.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  4  request present, one bit per requester
- req_ready  out  4  grant; a transfer occurs when req_valid[i] and req_ready[i] are both high
- req_a  in  128  operand A; requester i drives bits [32i+31:32i]
- req_b  in  128  operand B, same packing as req_a
- req_sub  in  4  1 = compute A − B
- req_cin  in  4  carry-in; used only when sub=0 and chain=0
- req_chain  in  4  carry-in comes from the stored carry of the previous operation
- req_lock  in  4  keep the grant on this requester for its next request
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  2  index of the requester that issued the operation
- rsp_result  out  32  sum or difference
- rsp_carry  out  1  carry out of bit 31
- rsp_overflow  out  1  signed overflow

## Operation
**Arithmetic.** For the granted requester:
- b_eff = sub ? ~b : b.
- c0 is selected in this order:
  - chain=1: c0 = carry_reg.
  - otherwise sub=1: c0 = 1.
  - otherwise: c0 = cin.
- {carry, result} = a + b_eff + c0, computed 33 bits wide.
- overflow = carry into bit 31 XOR carry out of bit 31.
- The existing rca_32bit may be used with carry_in = c0 and subtract_mode = sub.
- Chained subtraction follows the convention that carry = NOT borrow.

**Accept condition.** can_accept = !rsp_valid || rsp_ready.

**Arbitration.**
- Round-robin pointer last_grant, 2 bits. Priority order is last_grant+1, +2, +3, +4, all mod 4.
- At most one req_ready bit is high, and only when can_accept=1.
- req_ready is combinational from req_valid, can_accept, last_grant and lock state. It must not depend on that requester's own data signals.
- On an accepted transfer: last_grant ← the granted index.

**Lock.**
- Accepting a request with lock=1 sets lock_active=1 and lock_id=i.
- While lock_active=1:
  - only requester lock_id can be granted;
  - all other requesters stall even if valid.
- Accepting a request from lock_id with lock=0 clears lock_active, ending the sequence on that word.
- If lock_id deasserts req_valid while locked, the lock is held and nothing is granted.

**Carry register.** carry_reg ← carry on every accepted transfer, regardless of requester.

**Response FSM.**
- EMPTY (rsp_valid=0):
  - accept → FULL.
- FULL (rsp_valid=1):
  - rsp_ready=1 with a new accept → stay FULL, load the new result (back-to-back).
  - rsp_ready=1 with no accept → EMPTY.
  - rsp_ready=0 → hold; all rsp_* outputs stable.

## Timing
- Latency: a request accepted at edge N produces rsp_valid=1 with its data from edge N to N+1. The result is registered, with no combinational path from req_* to rsp_*.
- Throughput: one operation per cycle when rsp_ready stays high.
- rsp_ready low stalls everything: all req_ready bits drop in the same cycle, because can_accept is combinational from rsp_ready.
- Reset values (asynchronous assert, synchronous release):
  - rsp_valid=0; rsp_id, rsp_result, rsp_carry, rsp_overflow = 0.
  - last_grant=3, so requester 0 has first priority.
  - lock_active=0, lock_id=0, carry_reg=0.
- Reset mid-operation discards the buffered response and any active lock. Nothing is replayed.
- When all four requesters are valid, grants rotate 0,1,2,3,0… with no starvation. A requester waits at most 3 grants unless a lock is held.
- chain=1 on the first word after reset uses carry_reg=0.

## Test plan
- Single add, requester 2: a=0xFFFFFFFF, b=1, cin=0 → one cycle later rsp_id=2, result=0, carry=1, overflow=0.
- Subtract, requester 1: a=0x80000000, b=1, sub=1 → result=0x7FFFFFFF, carry=1, overflow=1. Also a=5, b=7, sub=1 → result=0xFFFFFFFE, carry=0.
- All four requesters valid continuously, rsp_ready=1 → grants and rsp_id sequence 0,1,2,3,0,1… with rsp_valid high every cycle after the first.
- 64-bit chained add by requester 3 while the others are valid:
  - word0 a=0xFFFFFFFF, b=1, lock=1;
  - word1 a=0, b=0, chain=1, lock=0;
  - → results 0x00000000 then 0x00000001, with no other rsp_id in between; requester 0 is granted next.
- Back-pressure: hold rsp_ready=0 for 3 cycles with a response buffered → rsp_* stable and req_ready=0. Release → the buffered response drains and a new accept occurs in the same cycle.
- Assert rst_n low while FULL and locked → rsp_valid=0 immediately. After release, requester 0 wins against requester 3 when both are valid.

Source files
------------

// File: rtl/rca_arbiter_if.sv
// Request/response bundle for the shared add/subtract unit.
// A beat transfers on a rising clk edge where valid and ready are both high.
// The producer holds its data stable until that edge.
interface rca_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_sub;
  logic [NREQ-1:0]       req_cin;
  logic [NREQ-1:0]       req_chain;
  logic [NREQ-1:0]       req_lock;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_carry;
  logic                  rsp_overflow;

  modport slave (
    input  req_valid, req_a, req_b, req_sub, req_cin, req_chain, req_lock, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_overflow
  );

  modport master (
    output req_valid, req_a, req_b, req_sub, req_cin, req_chain, req_lock, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_overflow
  );
endinterface

// File: rtl/rca_arbiter.sv
// Four requesters share one ripple-carry add/subtract datapath through a round-robin
// arbiter with lock/chain support and a single-entry registered response buffer.
module rca_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  rca_arbiter_if.slave bus,
  output logic         fsm_state
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state, state_next;
  logic [1:0]       last_grant, lock_id, gnt_idx, scan_idx;
  logic             lock_active, carry_reg;
  logic             gnt_found, can_accept, fire;
  logic [WIDTH-1:0] op_a, op_b_eff, sum;
  logic             op_sub, c0, carry_out, carry_msb_in;

  assign bus.rsp_valid = (state == FULL);
  assign can_accept    = !bus.rsp_valid || bus.rsp_ready;
  assign fire          = gnt_found && can_accept;
  assign fsm_state     = state;

  // A held lock pins the grant to lock_id even when it is idle.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = 2'd0;
    scan_idx  = 2'd0;
    if (lock_active) begin
      gnt_found = bus.req_valid[lock_id];
      gnt_idx   = lock_id;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        scan_idx = last_grant + 2'(k);
        if (!gnt_found && bus.req_valid[scan_idx]) begin
          gnt_found = 1'b1;
          gnt_idx   = scan_idx;
        end
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (fire) bus.req_ready[gnt_idx] = 1'b1;
  end

  // Chained words take their carry-in from the previous transfer, even for subtraction.
  always_comb begin
    logic c;
    op_a     = bus.req_a[int'(gnt_idx)*WIDTH +: WIDTH];
    op_sub   = bus.req_sub[gnt_idx];
    op_b_eff = op_sub ? ~bus.req_b[int'(gnt_idx)*WIDTH +: WIDTH]
                      :  bus.req_b[int'(gnt_idx)*WIDTH +: WIDTH];
    if (bus.req_chain[gnt_idx]) c0 = carry_reg;
    else if (op_sub)            c0 = 1'b1;
    else                        c0 = bus.req_cin[gnt_idx];
    sum          = '0;
    carry_msb_in = 1'b0;
    c            = c0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH-1) carry_msb_in = c;
      sum[i] = op_a[i] ^ op_b_eff[i] ^ c;
      c      = (op_a[i] & op_b_eff[i]) | (op_a[i] & c) | (op_b_eff[i] & c);
    end
    carry_out = c;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (fire) state_next = FULL;
      FULL:  if (bus.rsp_ready) state_next = fire ? FULL : EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant  <= 2'd3;
      lock_active <= 1'b0;
      lock_id     <= 2'd0;
      carry_reg   <= 1'b0;
    end else if (fire) begin
      last_grant  <= gnt_idx;
      carry_reg   <= carry_out;
      lock_active <= bus.req_lock[gnt_idx];
      if (bus.req_lock[gnt_idx]) lock_id <= gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_id       <= 2'd0;
      bus.rsp_result   <= '0;
      bus.rsp_carry    <= 1'b0;
      bus.rsp_overflow <= 1'b0;
    end else if (fire) begin
      bus.rsp_id       <= gnt_idx;
      bus.rsp_result   <= sum;
      bus.rsp_carry    <= carry_out;
      bus.rsp_overflow <= carry_msb_in ^ carry_out;
    end
  end
endmodule

// File: tb/tb_rca_arbiter.sv
// Directed bench for rca_arbiter: vector table for single operations plus
// hand-written sequences for rotation, lock/chain, back-pressure and reset.
module tb_rca_arbiter;
  logic clk;
  logic rst_n;
  logic fsm_state;
  int   checks;
  int   errors;
  logic [31:0] exp_q[$];

  rca_arbiter_if #(.NREQ(4), .WIDTH(32)) bus ();

  rca_arbiter #(.NREQ(4), .WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .fsm_state (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic        chain;
    logic [31:0] result;
    logic        carry;
    logic        ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sub   = '0;
    bus.req_cin   = '0;
    bus.req_chain = '0;
    bus.req_lock  = '0;
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic cin, input logic chain, input logic lock);
    bus.req_valid[id]      = 1'b1;
    bus.req_a[id*32 +: 32] = a;
    bus.req_b[id*32 +: 32] = b;
    bus.req_sub[id]        = sub;
    bus.req_cin[id]        = cin;
    bus.req_chain[id]      = chain;
    bus.req_lock[id]       = lock;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.rsp_ready = 1'b1;
    clear_reqs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_rsp(input string name, input int id, input logic [31:0] result);
    check({name, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({name, "_id"}, 32'(bus.rsp_id), 32'(id));
    check({name, "_result"}, bus.rsp_result, result);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0]  = '{2, 32'hFFFFFFFF, 32'h1,        0, 0, 0, 32'h00000000, 1, 0};
    vecs[1]  = '{1, 32'h80000000, 32'h1,        1, 0, 0, 32'h7FFFFFFF, 1, 1};
    vecs[2]  = '{1, 32'h5,        32'h7,        1, 0, 0, 32'hFFFFFFFE, 0, 0};
    vecs[3]  = '{0, 32'h7FFFFFFF, 32'h1,        0, 0, 0, 32'h80000000, 0, 1};
    vecs[4]  = '{3, 32'h1,        32'h2,        0, 1, 0, 32'h00000004, 0, 0};
    vecs[5]  = '{0, 32'h0,        32'h0,        0, 1, 1, 32'h00000000, 0, 0};
    vecs[6]  = '{2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 0, 32'hFFFFFFFF, 1, 0};
    vecs[7]  = '{1, 32'h10,       32'h20,       0, 0, 1, 32'h00000031, 0, 0};
    vecs[8]  = '{3, 32'h0,        32'h0,        1, 0, 0, 32'h00000000, 1, 0};
    vecs[9]  = '{0, 32'h0,        32'h1,        1, 0, 1, 32'hFFFFFFFF, 0, 0};
    vecs[10] = '{2, 32'h80000000, 32'h80000000, 0, 0, 0, 32'h00000000, 1, 1};

    rst_n         = 1'b0;
    bus.rsp_ready = 1'b1;
    clear_reqs();
    #2;
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("reset_rsp_result", bus.rsp_result, 32'd0);
    check("reset_rsp_flags", {30'd0, bus.rsp_carry, bus.rsp_overflow}, 32'd0);
    check("reset_state", 32'(fsm_state), 32'd0);
    do_reset();

    // Single operations, one requester at a time.
    for (int v = 0; v < 11; v++) begin
      @(negedge clk);
      clear_reqs();
      set_req(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].sub, vecs[v].cin, vecs[v].chain, 1'b0);
      #1;
      check($sformatf("vec%0d_ready", v), 32'(bus.req_ready), 32'(4'b0001 << vecs[v].id));
      @(posedge clk);
      #1;
      check_rsp($sformatf("vec%0d", v), vecs[v].id, vecs[v].result);
      check($sformatf("vec%0d_carry", v), 32'(bus.rsp_carry), 32'(vecs[v].carry));
      check($sformatf("vec%0d_ovf", v), 32'(bus.rsp_overflow), 32'(vecs[v].ovf));
    end
    @(negedge clk);
    clear_reqs();

    // All four valid: grants rotate 0,1,2,3,... and the buffer refills every cycle.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 32'h100 * i, 32'(i), 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("rr%0d_ready", k), 32'(bus.req_ready), 32'(4'b0001 << (k % 4)));
      exp_q.push_back(32'h101 * (k % 4));
      @(posedge clk);
      #1;
      check_rsp($sformatf("rr%0d", k), k % 4, exp_q.pop_front());
      @(negedge clk);
    end

    // 64-bit chained add by requester 3, including an idle cycle under lock.
    clear_reqs();
    set_req(3, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 1);
    #1;
    check("chain_w0_ready", 32'(bus.req_ready), 32'b1000);
    @(posedge clk);
    #1;
    check_rsp("chain_w0", 3, 32'h0);
    check("chain_w0_carry", 32'(bus.rsp_carry), 32'd1);
    @(negedge clk);
    clear_reqs();
    for (int i = 0; i < 3; i++) set_req(i, 32'h55, 32'h1, 0, 0, 0, 0);
    #1;
    check("lock_idle_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    check("lock_idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    set_req(3, 32'h0, 32'h0, 0, 0, 1, 0);
    #1;
    check("chain_w1_ready", 32'(bus.req_ready), 32'b1000);
    @(posedge clk);
    #1;
    check_rsp("chain_w1", 3, 32'h1);
    check("chain_w1_carry", 32'(bus.rsp_carry), 32'd0);
    @(negedge clk);
    bus.req_valid[3] = 1'b0;
    #1;
    check("after_lock_ready", 32'(bus.req_ready), 32'b0001);
    @(posedge clk);
    #1;
    check_rsp("after_lock", 0, 32'h56);

    // Back-pressure: buffer held, grants blocked, drain and refill in the same cycle.
    @(negedge clk);
    clear_reqs();
    set_req(1, 32'h3, 32'h4, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_rsp("bp_load", 1, 32'h7);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    set_req(2, 32'd10, 32'd20, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp%0d_ready", k), 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
      check_rsp($sformatf("bp%0d", k), 1, 32'h7);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.req_ready), 32'b0100);
    @(posedge clk);
    #1;
    check_rsp("bp_release", 2, 32'd30);

    // Reset while full and locked, then requester 0 beats requester 3.
    @(negedge clk);
    clear_reqs();
    set_req(3, 32'h9, 32'h1, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    check_rsp("pre_reset", 3, 32'hA);
    bus.rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_reset_state", 32'(fsm_state), 32'd0);
    @(negedge clk);
    clear_reqs();
    bus.rsp_ready = 1'b1;
    rst_n = 1'b1;
    set_req(0, 32'h1, 32'h1, 0, 0, 0, 0);
    set_req(3, 32'h2, 32'h2, 0, 0, 0, 0);
    #1;
    check("post_reset_ready", 32'(bus.req_ready), 32'b0001);
    @(posedge clk);
    #1;
    check_rsp("post_reset", 0, 32'h2);
    @(negedge clk);
    clear_reqs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
